// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared FSM states, quarter phases and sizing helpers for the I2C masters
package i2c_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_BIT   = 3'd2;
    localparam logic [2:0] ST_ACK   = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;
    localparam logic [2:0] ST_GAP   = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;
    localparam logic [2:0] ST_ERR   = 3'd7;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    function automatic int byte_count(input int reg_bytes, input int data_bytes);
        return 1 + reg_bytes + data_bytes;
    endfunction

    function automatic int index_width(input int num_regs);
        return (num_regs <= 2) ? 1 : $clog2(num_regs);
    endfunction

endpackage

// File: rtl/i2c_qtick.sv
// rtl/i2c_qtick.sv - SCL quarter-period divider; pulses qtick_o once every CLK_DIV enabled cycles
module i2c_qtick #(
    parameter int CLK_DIV = 125
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic qtick_o
);

    localparam int CW = (CLK_DIV <= 2) ? 1 : $clog2(CLK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          wrap;

    assign wrap    = (cnt_q == CW'(CLK_DIV - 1));
    assign qtick_o = en_i & ~clr_i & wrap;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = wrap ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/i2c_cfg_master.sv
// rtl/i2c_cfg_master.sv - write-only I2C master that walks a register table, with per-entry NACK retry
module i2c_cfg_master
    import i2c_pkg::*;
#(
    parameter logic [7:0] DEV_ADDR   = 8'hBA,
    parameter int         REG_BYTES  = 1,
    parameter int         DATA_BYTES = 2,
    parameter int         NUM_REGS   = 16,
    parameter int         CLK_DIV    = 125,
    parameter int         MAX_RETRY  = 3,
    localparam int        IW         = index_width(NUM_REGS)
) (
    input  logic                    clk1,
    input  logic                    reset,
    input  logic                    start,
    output logic [IW-1:0]           cfg_index,
    input  logic [8*REG_BYTES-1:0]  cfg_addr,
    input  logic [8*DATA_BYTES-1:0] cfg_data,
    input  logic                    sda_i,
    output logic                    sda_oe,
    output logic                    scl_oe,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [IW-1:0]           err_index
);

    localparam int NB = byte_count(REG_BYTES, DATA_BYTES);
    localparam int SW = 8 * NB;

    logic [2:0]    state_q, state_d;
    logic [1:0]    quarter_q, quarter_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [2:0]    byte_cnt_q, byte_cnt_d;
    logic [SW-1:0] shift_q, shift_d;
    logic [3:0]    retry_q, retry_d;
    logic          fail_q, fail_d;
    logic          nack_q, nack_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] err_idx_q, err_idx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          sda_oe_q, sda_oe_d;
    logic          scl_oe_q, scl_oe_d;
    logic          qtick;
    logic          start_acc;

    assign start_acc = start & ((state_q == ST_IDLE) | (state_q == ST_DONE) | (state_q == ST_ERR));

    i2c_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (
        .clk_i   (clk1),
        .rst_i   (reset),
        .en_i    (busy_q),
        .clr_i   (start_acc),
        .qtick_o (qtick)
    );

    // Returns {sda_oe, scl_oe} for a given phase; 1 means pull the line low.
    function automatic logic [1:0] line_drive(input logic [2:0] st, input logic [1:0] q, input logic b);
        logic scl_low;
        scl_low = (q == Q0) || (q == Q3);
        case (st)
            ST_START: line_drive = (q == Q0) ? 2'b00 : (q == Q3) ? 2'b11 : 2'b10;
            ST_BIT:   line_drive = {~b, scl_low};
            ST_ACK:   line_drive = {1'b0, scl_low};
            ST_STOP:  line_drive = (q == Q0) ? 2'b11 : (q == Q1) ? 2'b10 : 2'b00;
            default:  line_drive = 2'b00;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        quarter_d  = quarter_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        retry_d    = retry_q;
        fail_d     = fail_q;
        nack_d     = nack_q;
        idx_d      = idx_q;
        err_idx_d  = err_idx_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;

        if (start_acc) begin
            state_d   = ST_START;
            quarter_d = Q0;
            busy_d    = 1'b1;
            done_d    = 1'b0;
            err_d     = 1'b0;
            idx_d     = '0;
            retry_d   = '0;
            fail_d    = 1'b0;
        end else if (busy_q && qtick) begin
            quarter_d = quarter_q + 2'd1;
            case (state_q)
                ST_START: begin
                    // Latched a quarter in so cfg_* has settled after a cfg_index change.
                    if (quarter_q == Q0) begin
                        shift_d = {DEV_ADDR, cfg_addr, cfg_data};
                    end
                    if (quarter_q == Q3) begin
                        state_d    = ST_BIT;
                        bit_cnt_d  = '0;
                        byte_cnt_d = '0;
                        fail_d     = 1'b0;
                    end
                end
                ST_BIT: begin
                    if (quarter_q == Q3) begin
                        shift_d   = {shift_q[SW-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = ST_ACK;
                        end
                    end
                end
                ST_ACK: begin
                    if (quarter_q == Q2) begin
                        nack_d = sda_i;
                    end
                    if (quarter_q == Q3) begin
                        if (nack_q) begin
                            fail_d  = 1'b1;
                            state_d = ST_STOP;
                        end else if (byte_cnt_q == 3'(NB - 1)) begin
                            state_d = ST_STOP;
                        end else begin
                            state_d    = ST_BIT;
                            bit_cnt_d  = '0;
                            byte_cnt_d = byte_cnt_q + 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (quarter_q == Q3) begin
                        if (fail_q && (retry_q < 4'(MAX_RETRY))) begin
                            retry_d = retry_q + 4'd1;
                            state_d = ST_GAP;
                        end else if (fail_q) begin
                            err_d     = 1'b1;
                            err_idx_d = idx_q;
                            busy_d    = 1'b0;
                            state_d   = ST_ERR;
                        end else if (idx_q == IW'(NUM_REGS - 1)) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = ST_DONE;
                        end else begin
                            idx_d   = idx_q + IW'(1);
                            retry_d = '0;
                            state_d = ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (quarter_q == Q3) begin
                        state_d = ST_START;
                    end
                end
                default: ;
            endcase
        end

        // Drive is computed from the next phase so the registered pins line up with the phase.
        {sda_oe_d, scl_oe_d} = line_drive(state_d, quarter_d, shift_d[SW-1]);
    end

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            quarter_q  <= Q0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            retry_q    <= '0;
            fail_q     <= 1'b0;
            nack_q     <= 1'b0;
            idx_q      <= '0;
            err_idx_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            sda_oe_q   <= 1'b0;
            scl_oe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            quarter_q  <= quarter_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            retry_q    <= retry_d;
            fail_q     <= fail_d;
            nack_q     <= nack_d;
            idx_q      <= idx_d;
            err_idx_q  <= err_idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            sda_oe_q   <= sda_oe_d;
            scl_oe_q   <= scl_oe_d;
        end
    end

    assign cfg_index = idx_q;
    assign err_index = err_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign sda_oe    = sda_oe_q;
    assign scl_oe    = scl_oe_q;

endmodule

// File: tb/tb_i2c_cfg_master.sv
// tb/tb_i2c_cfg_master.sv - directed bench with a bus-decoding I2C slave model for i2c_cfg_master
module tb_i2c_cfg_master;

    localparam int CLK_DIV  = 4;
    localparam int BIT_CYC  = 4 * CLK_DIV;
    localparam int FRAME_TO_FRAME = 38 * BIT_CYC + BIT_CYC;

    logic        clk1 = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  cfg_index;
    logic [7:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic        sda_i;
    logic        sda_oe, scl_oe, busy, done, err;
    logic [1:0]  err_index;

    i2c_cfg_master #(
        .DEV_ADDR   (8'hBA),
        .REG_BYTES  (1),
        .DATA_BYTES (2),
        .NUM_REGS   (3),
        .CLK_DIV    (CLK_DIV),
        .MAX_RETRY  (2)
    ) dut (
        .clk1      (clk1),
        .reset     (reset),
        .start     (start),
        .cfg_index (cfg_index),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .sda_i     (sda_i),
        .sda_oe    (sda_oe),
        .scl_oe    (scl_oe),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_index (err_index)
    );

    always #5 clk1 = ~clk1;

    always_comb begin
        case (cfg_index)
            2'd0:    {cfg_addr, cfg_data} = 24'h011234;
            2'd1:    {cfg_addr, cfg_data} = 24'h02ABCD;
            default: {cfg_addr, cfg_data} = 24'h200005;
        endcase
    end

    logic slave_ack = 1'b0;
    assign sda_i = ~(sda_oe | slave_ack);

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Slave model: decodes START/STOP and bytes from the open-drain lines, and answers ACKs.
    int          cyc = 0;
    int          nack_mode = 0;
    int          frame_count = 0;
    logic [55:0] frame_val [16];
    int          frame_len [16];
    int          frame_t   [16];
    int          in_frame = 0;
    int          bitn = 0;
    int          nbytes = 0;
    logic [7:0]  cur_byte = 8'h00;
    logic [55:0] acc = '0;
    logic        prev_scl = 1'b1;
    logic        prev_sda = 1'b1;

    always @(posedge clk1) cyc++;

    always @(negedge clk1) begin
        logic scl_l, sda_l;
        scl_l = ~scl_oe;
        sda_l = ~(sda_oe | slave_ack);
        if (reset) begin
            in_frame  = 0;
            bitn      = 0;
            slave_ack = 1'b0;
        end else if (scl_l && prev_scl && prev_sda && !sda_l) begin
            in_frame = 1;
            bitn     = 0;
            nbytes   = 0;
            acc      = '0;
            if (frame_count < 16) frame_t[frame_count] = cyc;
        end else if (scl_l && prev_scl && !prev_sda && sda_l && in_frame != 0) begin
            if (frame_count < 16) begin
                frame_val[frame_count] = acc;
                frame_len[frame_count] = nbytes;
            end
            frame_count++;
            in_frame = 0;
        end else if (in_frame != 0 && !prev_scl && scl_l) begin
            if (bitn < 8) begin
                cur_byte = {cur_byte[6:0], sda_l};
                bitn++;
                if (bitn == 8) begin
                    acc = {acc[47:0], cur_byte};
                    nbytes++;
                end
            end else if (bitn == 10) begin
                bitn = 9;
            end
        end else if (in_frame != 0 && prev_scl && !scl_l) begin
            if (bitn == 8) begin
                slave_ack = !((nack_mode == 1 && frame_count == 1 && nbytes == 2) ||
                              (nack_mode == 2 && nbytes == 1));
                bitn = 10;
            end else if (bitn == 9) begin
                slave_ack = 1'b0;
                bitn = 0;
            end
        end
        prev_scl = scl_l;
        prev_sda = sda_l;
    end

    task automatic clear_rec();
        frame_count = 0;
        in_frame    = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk1);
        start = 1'b1;
        @(negedge clk1);
        start = 1'b0;
    endtask

    task automatic wait_end(input int limit);
        int k;
        k = 0;
        while (!(done || err) && k < limit) begin
            @(negedge clk1);
            k++;
        end
        check("run_ends", 64'(done | err), 64'd1);
    endtask

    initial begin
        logic bad;
        int   k;

        repeat (3) @(negedge clk1);
        reset = 1'b0;
        @(negedge clk1);
        check("rst_sda_oe", 64'(sda_oe), 64'd0);
        check("rst_scl_oe", 64'(scl_oe), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_cfg_index", 64'(cfg_index), 64'd0);
        check("rst_err_index", 64'(err_index), 64'd0);

        bad = 1'b0;
        repeat (1000) begin
            @(negedge clk1);
            if (sda_oe || scl_oe || busy || cfg_index != 2'd0) bad = 1'b1;
        end
        check("idle_quiet", 64'(bad), 64'd0);

        // Run 1: all ACK, with a stray start mid-frame
        nack_mode = 0;
        clear_rec();
        pulse_start();
        repeat (200) @(negedge clk1);
        pulse_start();
        wait_end(6000);
        check("r1_frames", 64'(frame_count), 64'd3);
        check("r1_f0", 64'(frame_val[0]), 64'hBA011234);
        check("r1_f1", 64'(frame_val[1]), 64'hBA02ABCD);
        check("r1_f2", 64'(frame_val[2]), 64'hBA200005);
        check("r1_len2", 64'(frame_len[2]), 64'd4);
        check("r1_gap01", 64'(frame_t[1] - frame_t[0]), 64'(FRAME_TO_FRAME));
        check("r1_gap12", 64'(frame_t[2] - frame_t[1]), 64'(FRAME_TO_FRAME));
        check("r1_done", 64'(done), 64'd1);
        check("r1_busy", 64'(busy), 64'd0);
        check("r1_err", 64'(err), 64'd0);
        check("r1_index", 64'(cfg_index), 64'd2);

        // Run 2: NACK on entry 1's first attempt, restart from DONE
        nack_mode = 1;
        clear_rec();
        pulse_start();
        check("restart_done_clr", 64'(done), 64'd0);
        check("restart_index", 64'(cfg_index), 64'd0);
        check("restart_busy", 64'(busy), 64'd1);
        wait_end(8000);
        check("r2_frames", 64'(frame_count), 64'd4);
        check("r2_f0", 64'(frame_val[0]), 64'hBA011234);
        check("r2_f1_aborted", 64'(frame_val[1]), 64'hBA02);
        check("r2_f1_len", 64'(frame_len[1]), 64'd2);
        check("r2_f2_retry", 64'(frame_val[2]), 64'hBA02ABCD);
        check("r2_f3", 64'(frame_val[3]), 64'hBA200005);
        check("r2_done", 64'(done), 64'd1);
        check("r2_err", 64'(err), 64'd0);

        // Run 3: device address always NACKed
        nack_mode = 2;
        clear_rec();
        pulse_start();
        wait_end(8000);
        check("r3_frames", 64'(frame_count), 64'd3);
        check("r3_f0", 64'(frame_val[0]), 64'hBA);
        check("r3_f2_len", 64'(frame_len[2]), 64'd1);
        check("r3_err", 64'(err), 64'd1);
        check("r3_err_index", 64'(err_index), 64'd0);
        check("r3_busy", 64'(busy), 64'd0);
        check("r3_done", 64'(done), 64'd0);

        // Run 4: restart from ERR, then reset during entry 1's data byte
        nack_mode = 0;
        clear_rec();
        pulse_start();
        check("restart_err_clr", 64'(err), 64'd0);
        k = 0;
        while (!(frame_count >= 1 && in_frame != 0 && nbytes >= 2) && k < 4000) begin
            @(negedge clk1);
            k++;
        end
        check("r4_reached_data", 64'(frame_count >= 1 && in_frame != 0 && nbytes >= 2), 64'd1);
        check("r4_index_before", 64'(cfg_index), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("r4_async_sda", 64'(sda_oe), 64'd0);
        check("r4_async_scl", 64'(scl_oe), 64'd0);
        check("r4_busy", 64'(busy), 64'd0);
        check("r4_cfg_index", 64'(cfg_index), 64'd0);
        check("r4_done_err", 64'({done, err}), 64'd0);
        check("r4_err_index", 64'(err_index), 64'd0);
        repeat (3) @(negedge clk1);
        reset = 1'b0;
        repeat (50) @(negedge clk1);
        check("r4_stays_idle", 64'({sda_oe, scl_oe, busy}), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
